// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Fetch-to-decode FIFO of {pc, inst} pairs with flush on redirect.
// Revision : 1.0
// ============================================================================
module inst_fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_w, pop_w;
  logic [63:0]      head_w;

  // Ready and valid come from the counter only, so no ready-to-ready path exists.
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push_w    = in_valid & in_ready & ~flush;
  assign pop_w     = out_valid & out_ready & ~flush;
  assign head_w    = mem_q[rp_q];
  assign out_pc    = out_valid ? head_w[63:32] : 32'h0;
  assign out_inst  = out_valid ? head_w[31:0]  : 32'h0;
  assign count     = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_w) wp_d = wp_q + PTR_W'(1);
      if (pop_w)  rp_d = rp_q + PTR_W'(1);
      case ({push_w, pop_w})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wp_q] <= {in_pc, in_inst};
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    cnt_q <= CNT_W'(DEPTH));
  a_valid_cnt: assert property (@(posedge clk) disable iff (reset)
    out_valid == (cnt_q != '0));
  a_ready_cnt: assert property (@(posedge clk) disable iff (reset)
    in_ready == (cnt_q != CNT_W'(DEPTH)));
  a_ptr_cnt:   assert property (@(posedge clk) disable iff (reset)
    PTR_W'(wp_q - rp_q) == cnt_q[PTR_W-1:0]);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Directed and random checks of inst_fetch_queue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];
  bit          chk_en = 1'b0;
  bit          last_push = 1'b0;
  bit          last_clear = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: a plain queue of {pc,inst}; acceptance decided from its size before the edge.
  always @(posedge clk) begin
    bit full, empty;
    full       = (mq.size() == DEPTH);
    empty      = (mq.size() == 0);
    last_push  = 1'b0;
    last_clear = 1'b0;
    if (reset || flush) begin
      mq.delete();
      last_clear = 1'b1;
      if (reset) chk_en = 1'b1;
    end else begin
      if (out_ready && !empty) void'(mq.pop_front());
      if (in_valid && !full) begin
        mq.push_back({in_pc, in_inst});
        last_push = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    logic [63:0] head;
    #1;
    if (chk_en) begin
      head = (mq.size() != 0) ? mq[0] : 64'h0;
      check("m_count",    64'(count),     64'(mq.size()));
      check("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("m_in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
      check("m_head",      {out_pc, out_inst}, head);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
    step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_out",   {out_pc, out_inst}, 64'h0);
    reset = 1'b0;

    // Three pushes with decode stalled
    in_valid = 1'b1; in_inst = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'(i * 4);
      step();
    end
    check("t1_count", 64'(count), 64'd3);
    check("t1_pc",    64'(out_pc), 64'h0);
    check("t1_ready", 64'(in_ready), 64'd1);

    // Fill, then push+pop while full: only the pop happens
    in_pc = 32'hC; step();
    check("t2_full_cnt",   64'(count), 64'd4);
    check("t2_full_ready", 64'(in_ready), 64'd0);
    in_pc = 32'h10; out_ready = 1'b1; step();
    check("t2_pop_cnt", 64'(count), 64'd3);
    check("t2_pop_pc",  64'(out_pc), 64'h4);
    check("t2_ready",   64'(in_ready), 64'd1);
    out_ready = 1'b0; step();
    check("t2_acc_cnt", 64'(count), 64'd4);

    // Flush with 3 entries and same-cycle push/pop
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("t4_pre_cnt", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD; in_inst = 32'hBEEF; step();
    check("t4_cnt",   64'(count), 64'd0);
    check("t4_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; step();
    check("t4_still_empty", 64'(out_valid), 64'd0);

    // Continuous streaming from empty, 16 items over several pointer wraps
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_pc = 32'h200 + 32'(4 * k); in_inst = 32'hA000 + 32'(k);
      step();
      check("t3_valid", 64'(out_valid), 64'd1);
      check("t3_order", {out_pc, out_inst}, {32'h200 + 32'(4 * k), 32'hA000 + 32'(k)});
    end
    in_valid = 1'b0; step();
    check("t3_drained", 64'(count), 64'd0);

    // Branch word reaches decode intact; its B-immediate is -4
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'hFE0A8EE3; step();
    in_valid = 1'b0;
    check("t5_pc",   64'(out_pc), 64'h100);
    check("t5_inst", 64'(out_inst), 64'hFE0A8EE3);
    check("t5_immb", 64'(imm_b(out_inst)), 64'hFFFFFFFC);
    out_ready = 1'b1; step();
    check("t5_popped", 64'(out_valid), 64'd0);

    // Random traffic with a mid-stream reset
    for (int c = 0; c < 300; c++) begin
      if (!(in_valid && !last_push && !last_clear)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = $urandom();
        in_inst  = $urandom();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = (c == 150);
      step();
      if (c == 150) begin
        check("t6_rst_cnt",   64'(count), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
      end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
